dekatron_carry_tracker: RTL and testbench
=========================================

// Module: dekatron_carry_tracker
// PURPOSE
//  Multi-digit, parametrised carry/borrow tracker for chains of ring-counter (dekatron) digits.
//  Each digit presents a POSITIONS-wide cathode one-hot. The block debounces it into a
//  registered position and latches end-of-ring flags. It also issues single-cycle carry and
//  borrow pulses on wrap-around and flags illegal cathode patterns.
//  Sits between the cathode sense inputs and the counter/ALU sequencing logic.
// PARAMETERS
//  POSITIONS      10  cathodes per digit (>=3); position 0 = low end, POSITIONS-1 = high end
//  DIGITS          3  digits in the chain (>=1); digit 0 = least significant
//  STABLE_CYCLES   2  consecutive identical samples required to accept a pattern (>=1)
//  PW = $clog2(POSITIONS)
// PORTS
//  Clk          in   1               system clock, all state on rising edge
//  Rst          in   1               asynchronous, active-high reset
//  En           in   1               sample enable; 0 freezes all state except Error clear
//  In           in   DIGITS*POSITIONS  cathode sense, digit d at In[d*POSITIONS +: POSITIONS]
//  ErrClr       in   1               clears all Error bits
//  Pos          out  DIGITS*PW       accepted binary position, digit d at Pos[d*PW +: PW]
//  Valid        out  DIGITS          digit has an accepted position since reset
//  CarryLow     out  DIGITS          accepted position == 0
//  CarryHigh    out  DIGITS          accepted position == POSITIONS-1
//  CarryPulse   out  DIGITS          1-cycle: accepted move POSITIONS-1 -> 0
//  BorrowPulse  out  DIGITS          1-cycle: accepted move 0 -> POSITIONS-1
//  Error        out  DIGITS          sticky: multi-hot pattern or non-adjacent jump accepted
//  Overflow     out  1               = CarryPulse[DIGITS-1]
//  Underflow    out  1               = BorrowPulse[DIGITS-1]
//  Zero         out  1               all digits Valid and at position 0 (registered)
// BEHAVIOUR
//  Reset (async, immediate): Pos=0, Valid=0, CarryLow=0, CarryHigh=0, all pulses 0,
//   Error=0, Zero=0, filter candidates cleared, stability counters 0.
//  Per digit, each En=1 cycle: compare slice with candidate register.
//   - differs: candidate<=slice, counter<=1; equal: counter saturates at STABLE_CYCLES.
//   - acceptance when counter reaches STABLE_CYCLES and candidate is non-zero: one edge only
//     (no re-acceptance while pattern held). Latency: slice change in cycle t -> outputs
//     updated in cycle t+STABLE_CYCLES.
//   - all-zero pattern: normal inter-cathode transit; never accepted, never an error; hold.
//   - multi-hot accepted: Error[d]<=1; Pos/Valid/flags unchanged, no pulse.
//   - one-hot accepted: Pos<=index; Valid<=1; CarryLow/CarryHigh recomputed from new Pos.
//     Step classification vs previous Pos (only if Valid was already 1):
//     +1 mod POSITIONS: P-1->0 gives CarryPulse; -1 mod POSITIONS: 0->P-1 gives BorrowPulse;
//     same position: nothing; any other jump: Error[d]<=1, no pulse, Pos still updated.
//     First acceptance after reset: no pulse, no step error.
//  Pulses high exactly one cycle; digits are independent (simultaneous pulses allowed).
//  En=0: candidates, counters, Pos, Valid, flags hold; pulses forced 0 that cycle.
//  ErrClr: clears Error next edge regardless of En; a new error on same edge wins (set).
//  Zero registered from the post-update Pos/Valid, same edge as Pos.
//  Reset asserted mid-transit: all state cleared; after release digit re-acquires with no
//   pulse on first acceptance.
// TESTING
//  1. STABLE_CYCLES=2, digit0 0->1 one-hot held -> Pos[0]=1 two cycles after change, no pulse,
//     CarryLow[0] 1->0.
//  2. Digit0 at 9, In slice 9 -> all-zero 1 cycle -> 0 -> CarryPulse[0]=1 for exactly one
//     cycle, CarryLow[0]=1, CarryHigh[0]=0, no Error.
//  3. Digit2 at 0 -> 9 -> BorrowPulse[2]=1 and Underflow=1 one cycle; digit 2 at 9 -> 0 ->
//     Overflow=1.
//  4. Glitch: digit1 pattern 0x004 for 1 cycle between stable 0x002 -> Pos[1] stays 1,
//     no pulse; jump 3 -> 7 held -> Error[1]=1, Pos=7; ErrClr -> Error[1]=0.
//  5. Multi-hot 0x006 held 2 cycles -> Error set, Pos unchanged; En=0 during a 9->0 move ->
//     nothing until En=1, then CarryPulse after STABLE_CYCLES.
//  6. Rst pulse mid-filter -> all outputs 0 asynchronously; first accepted 0 -> Valid=1,
//     no pulse; all digits at 0 -> Zero=1.

Source files
------------

// File: rtl/dekatron_carry_tracker.sv
// Debounces per-digit dekatron cathode one-hots into binary positions and reports
// end-of-ring carry/borrow pulses, ring-end flags, illegal-pattern errors and chain zero.
module dekatron_carry_tracker #(
    parameter int POSITIONS     = 10,
    parameter int DIGITS        = 3,
    parameter int STABLE_CYCLES = 2,
    localparam int PW           = $clog2(POSITIONS)
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic                        En,
    input  logic [DIGITS*POSITIONS-1:0] In,
    input  logic                        ErrClr,
    output logic [DIGITS*PW-1:0]        Pos,
    output logic [DIGITS-1:0]           Valid,
    output logic [DIGITS-1:0]           CarryLow,
    output logic [DIGITS-1:0]           CarryHigh,
    output logic [DIGITS-1:0]           CarryPulse,
    output logic [DIGITS-1:0]           BorrowPulse,
    output logic [DIGITS-1:0]           Error,
    output logic                        Overflow,
    output logic                        Underflow,
    output logic                        Zero
);

    localparam int            CW       = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
    localparam logic [PW-1:0] POS_LAST = PW'(POSITIONS - 1);

    logic [POSITIONS-1:0] cand     [DIGITS];
    logic [POSITIONS-1:0] cand_nxt [DIGITS];
    logic [CW-1:0]        cnt      [DIGITS];
    logic [CW-1:0]        cnt_nxt  [DIGITS];
    logic [PW-1:0]        pos_r    [DIGITS];
    logic [PW-1:0]        pos_nxt  [DIGITS];
    logic [DIGITS-1:0]    valid_nxt, low_nxt, high_nxt, carry_nxt, borrow_nxt, err_nxt;
    logic                 zero_nxt;

    function automatic logic is_onehot(input logic [POSITIONS-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < POSITIONS; i++) n += int'(v[i]);
        return (n == 1);
    endfunction

    function automatic logic [PW-1:0] to_index(input logic [POSITIONS-1:0] v);
        logic [PW-1:0] r;
        r = '0;
        for (int i = 0; i < POSITIONS; i++) if (v[i]) r = PW'(i);
        return r;
    endfunction

    always_comb begin
        zero_nxt   = 1'b1;
        valid_nxt  = Valid;
        low_nxt    = CarryLow;
        high_nxt   = CarryHigh;
        carry_nxt  = '0;
        borrow_nxt = '0;
        err_nxt    = Error & ~{DIGITS{ErrClr}};
        for (int d = 0; d < DIGITS; d++) begin
            logic [POSITIONS-1:0] slice;
            logic                 accept;
            logic [PW-1:0]        idx, step_up, step_dn;
            slice       = In[d*POSITIONS +: POSITIONS];
            cand_nxt[d] = cand[d];
            cnt_nxt[d]  = cnt[d];
            pos_nxt[d]  = pos_r[d];
            accept      = 1'b0;
            idx         = to_index(slice);
            step_up     = (pos_r[d] == POS_LAST) ? '0 : pos_r[d] + PW'(1);
            step_dn     = (pos_r[d] == '0) ? POS_LAST : pos_r[d] - PW'(1);
            if (En) begin
                if (slice != cand[d]) begin
                    cand_nxt[d] = slice;
                    cnt_nxt[d]  = CW'(1);
                end else if (cnt[d] != CNT_MAX) begin
                    cnt_nxt[d] = cnt[d] + CW'(1);
                end
                // Accept only on the edge where the run first reaches the threshold.
                accept = (cnt_nxt[d] == CNT_MAX) && ((cnt[d] != CNT_MAX) || (slice != cand[d]));
            end
            if (accept && (slice != '0)) begin
                if (!is_onehot(slice)) begin
                    err_nxt[d] = 1'b1;
                end else begin
                    if (Valid[d] && (idx != pos_r[d])) begin
                        if (idx == step_up)      carry_nxt[d]  = (pos_r[d] == POS_LAST);
                        else if (idx == step_dn) borrow_nxt[d] = (pos_r[d] == '0);
                        else                     err_nxt[d]    = 1'b1;
                    end
                    pos_nxt[d]   = idx;
                    valid_nxt[d] = 1'b1;
                    low_nxt[d]   = (idx == '0);
                    high_nxt[d]  = (idx == POS_LAST);
                end
            end
            if (!(valid_nxt[d] && (pos_nxt[d] == '0))) zero_nxt = 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int d = 0; d < DIGITS; d++) begin
                cand[d]  <= '0;
                cnt[d]   <= '0;
                pos_r[d] <= '0;
            end
            Valid       <= '0;
            CarryLow    <= '0;
            CarryHigh   <= '0;
            CarryPulse  <= '0;
            BorrowPulse <= '0;
            Error       <= '0;
            Zero        <= 1'b0;
        end else begin
            for (int d = 0; d < DIGITS; d++) begin
                cand[d]  <= cand_nxt[d];
                cnt[d]   <= cnt_nxt[d];
                pos_r[d] <= pos_nxt[d];
            end
            Valid       <= valid_nxt;
            CarryLow    <= low_nxt;
            CarryHigh   <= high_nxt;
            CarryPulse  <= carry_nxt;
            BorrowPulse <= borrow_nxt;
            Error       <= err_nxt;
            Zero        <= zero_nxt;
        end
    end

    always_comb begin
        Pos = '0;
        for (int d = 0; d < DIGITS; d++) Pos[d*PW +: PW] = pos_r[d];
    end

    assign Overflow  = CarryPulse[DIGITS-1];
    assign Underflow = BorrowPulse[DIGITS-1];

endmodule

// File: tb/tb_dekatron_carry_tracker.sv
// Self-checking bench for dekatron_carry_tracker: directed vector table, corner sequences
// and randomized cathode activity against a sample-history reference model.
module tb_dekatron_carry_tracker;

    localparam int P  = 10;
    localparam int D  = 3;
    localparam int S  = 2;
    localparam int PW = 4;

    logic            Clk = 1'b0;
    logic            Rst;
    logic            En;
    logic [D*P-1:0]  In;
    logic            ErrClr;
    logic [D*PW-1:0] Pos;
    logic [D-1:0]    Valid, CarryLow, CarryHigh, CarryPulse, BorrowPulse, Error;
    logic            Overflow, Underflow, Zero;

    dekatron_carry_tracker #(.POSITIONS(P), .DIGITS(D), .STABLE_CYCLES(S)) dut (
        .Clk(Clk), .Rst(Rst), .En(En), .In(In), .ErrClr(ErrClr),
        .Pos(Pos), .Valid(Valid), .CarryLow(CarryLow), .CarryHigh(CarryHigh),
        .CarryPulse(CarryPulse), .BorrowPulse(BorrowPulse), .Error(Error),
        .Overflow(Overflow), .Underflow(Underflow), .Zero(Zero)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: history of sampled patterns per digit (newest at index 0).
    logic [P-1:0] hist [D][8];
    int           hlen [D];
    int           m_pos [D];
    logic [D-1:0] m_valid, m_low, m_high, m_carry, m_borrow, m_err;
    logic         m_zero;

    function automatic void model_reset();
        for (int d = 0; d < D; d++) begin
            hlen[d]  = 0;
            m_pos[d] = 0;
            for (int k = 0; k < 8; k++) hist[d][k] = '0;
        end
        m_valid = '0; m_low = '0; m_high = '0;
        m_carry = '0; m_borrow = '0; m_err = '0; m_zero = 1'b0;
    endfunction

    function automatic void model_step();
        m_carry  = '0;
        m_borrow = '0;
        if (ErrClr) m_err = '0;
        if (En) begin
            for (int d = 0; d < D; d++) begin
                logic [P-1:0] cur;
                logic         acc;
                int           idx, diff;
                for (int k = 7; k > 0; k--) hist[d][k] = hist[d][k-1];
                hist[d][0] = In[d*P +: P];
                if (hlen[d] < 1000) hlen[d]++;
                cur = hist[d][0];
                acc = (hlen[d] >= S);
                for (int k = 0; k < S; k++) if (hist[d][k] != cur) acc = 1'b0;
                if (hlen[d] > S && hist[d][S] == cur) acc = 1'b0;
                if (acc && cur != '0) begin
                    if ($countones(cur) != 1) begin
                        m_err[d] = 1'b1;
                    end else begin
                        idx = 0;
                        for (int i = 0; i < P; i++) if (cur[i]) idx = i;
                        if (m_valid[d]) begin
                            diff = (idx - m_pos[d] + P) % P;
                            if (diff == 1)          m_carry[d]  = (idx == 0);
                            else if (diff == P - 1) m_borrow[d] = (idx == P - 1);
                            else if (diff != 0)     m_err[d]    = 1'b1;
                        end
                        m_pos[d]   = idx;
                        m_valid[d] = 1'b1;
                        m_low[d]   = (idx == 0);
                        m_high[d]  = (idx == P - 1);
                    end
                end
            end
        end
        m_zero = (m_valid == '1);
        for (int d = 0; d < D; d++) if (m_pos[d] != 0) m_zero = 1'b0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        logic [D*PW-1:0] ep;
        for (int d = 0; d < D; d++) ep[d*PW +: PW] = PW'(m_pos[d]);
        check("pos",       32'(Pos),         32'(ep));
        check("valid",     32'(Valid),       32'(m_valid));
        check("carry_low", 32'(CarryLow),    32'(m_low));
        check("carry_hi",  32'(CarryHigh),   32'(m_high));
        check("carry_p",   32'(CarryPulse),  32'(m_carry));
        check("borrow_p",  32'(BorrowPulse), 32'(m_borrow));
        check("error",     32'(Error),       32'(m_err));
        check("overflow",  32'(Overflow),    32'(m_carry[D-1]));
        check("underflow", 32'(Underflow),   32'(m_borrow[D-1]));
        check("zero",      32'(Zero),        32'(m_zero));
    endtask

    task automatic tick();
        @(posedge Clk);
        if (!Rst) model_step();
        #1;
        compare_all();
    endtask

    task automatic set_digit(input int d, input logic [P-1:0] pat);
        In[d*P +: P] = pat;
    endtask

    task automatic async_reset();
        Rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        check("rst_pos", 32'(Pos), 32'd0);
        tick();
        Rst = 1'b0;
    endtask

    typedef struct {
        logic [D*P-1:0]  in;
        logic [D*PW-1:0] pos;
        logic [D-1:0]    valid, low, high, carry, borrow;
    } vec_t;
    vec_t tbl [13];

    int cur [D];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{30'h001, 12'h000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
        tbl[1]  = '{30'h001, 12'h000, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000};
        tbl[2]  = '{30'h002, 12'h000, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000};
        tbl[3]  = '{30'h002, 12'h001, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000};
        tbl[4]  = '{30'h001, 12'h001, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000};
        tbl[5]  = '{30'h001, 12'h000, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000};
        tbl[6]  = '{30'h200, 12'h000, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000};
        tbl[7]  = '{30'h200, 12'h009, 3'b001, 3'b000, 3'b001, 3'b000, 3'b001};
        tbl[8]  = '{30'h200, 12'h009, 3'b001, 3'b000, 3'b001, 3'b000, 3'b000};
        tbl[9]  = '{30'h000, 12'h009, 3'b001, 3'b000, 3'b001, 3'b000, 3'b000};
        tbl[10] = '{30'h001, 12'h009, 3'b001, 3'b000, 3'b001, 3'b000, 3'b000};
        tbl[11] = '{30'h001, 12'h000, 3'b001, 3'b001, 3'b000, 3'b001, 3'b000};
        tbl[12] = '{30'h001, 12'h000, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000};

        Rst = 1'b1; En = 1'b0; ErrClr = 1'b0; In = '0;
        model_reset();
        #12;
        compare_all();
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        En  = 1'b1;

        // Directed table: digit 0 acquisition, step, borrow, transit and carry.
        for (int i = 0; i < 13; i++) begin
            In = tbl[i].in;
            tick();
            check("tbl_pos",    32'(Pos),         32'(tbl[i].pos));
            check("tbl_valid",  32'(Valid),       32'(tbl[i].valid));
            check("tbl_low",    32'(CarryLow),    32'(tbl[i].low));
            check("tbl_high",   32'(CarryHigh),   32'(tbl[i].high));
            check("tbl_carry",  32'(CarryPulse),  32'(tbl[i].carry));
            check("tbl_borrow", 32'(BorrowPulse), 32'(tbl[i].borrow));
            check("tbl_error",  32'(Error),       32'd0);
        end

        // Most significant digit: underflow then overflow.
        set_digit(2, 10'h001); tick(); tick();
        set_digit(2, 10'h200); tick(); tick();
        check("underflow_hi", 32'(Underflow), 32'd1);
        check("borrow_d2", 32'(BorrowPulse), 32'b100);
        tick();
        check("underflow_lo", 32'(Underflow), 32'd0);
        set_digit(2, 10'h001); tick(); tick();
        check("overflow_hi", 32'(Overflow), 32'd1);
        check("pos_d2", 32'(Pos[8 +: 4]), 32'd0);

        // Digit 1 glitch rejection, then a non-adjacent jump and error clear.
        set_digit(1, 10'h002); tick(); tick();
        set_digit(1, 10'h004); tick();
        set_digit(1, 10'h002); tick(); tick(); tick();
        check("glitch_pos", 32'(Pos[4 +: 4]), 32'd1);
        check("glitch_err", 32'(Error[1]), 32'd0);
        set_digit(1, 10'h004); tick(); tick();
        set_digit(1, 10'h008); tick(); tick();
        set_digit(1, 10'h080); tick(); tick();
        check("jump_err", 32'(Error[1]), 32'd1);
        check("jump_pos", 32'(Pos[4 +: 4]), 32'd7);
        ErrClr = 1'b1; tick(); ErrClr = 1'b0;
        check("errclr", 32'(Error[1]), 32'd0);

        // Multi-hot, then a carry move spanning En=0.
        set_digit(1, 10'h006); tick(); tick();
        check("multihot_err", 32'(Error[1]), 32'd1);
        check("multihot_pos", 32'(Pos[4 +: 4]), 32'd7);
        set_digit(0, 10'h200); tick(); tick();
        En = 1'b0;
        set_digit(0, 10'h001); tick(); tick(); tick();
        check("en0_pos", 32'(Pos[0 +: 4]), 32'd9);
        check("en0_carry", 32'(CarryPulse), 32'd0);
        En = 1'b1; tick();
        check("en1_wait", 32'(CarryPulse[0]), 32'd0);
        tick();
        check("en1_carry", 32'(CarryPulse[0]), 32'd1);
        check("en1_pos", 32'(Pos[0 +: 4]), 32'd0);

        // Reset mid-filter, then re-acquire all digits at zero.
        set_digit(0, 10'h002); tick();
        async_reset();
        check("rst_valid", 32'(Valid), 32'd0);
        In = '0;
        for (int d = 0; d < D; d++) set_digit(d, 10'h001);
        tick(); tick();
        check("reacq_valid", 32'(Valid), 32'b111);
        check("reacq_zero", 32'(Zero), 32'd1);
        check("reacq_pulse", 32'({CarryPulse, BorrowPulse}), 32'd0);

        // Randomized cathode activity.
        for (int d = 0; d < D; d++) cur[d] = 0;
        for (int n = 0; n < 3000; n++) begin
            En     = ($urandom_range(0, 9) != 0);
            ErrClr = ($urandom_range(0, 15) == 0);
            for (int d = 0; d < D; d++) begin
                int r;
                r = $urandom_range(0, 99);
                if (r < 50) begin
                end else if (r < 70) begin
                    cur[d] = ($urandom_range(0, 1) == 1) ? (cur[d] + 1) % P : (cur[d] + P - 1) % P;
                    set_digit(d, P'(1) << cur[d]);
                end else if (r < 80) begin
                    set_digit(d, '0);
                end else if (r < 88) begin
                    cur[d] = $urandom_range(0, P - 1);
                    set_digit(d, P'(1) << cur[d]);
                end else if (r < 95) begin
                    int a, b;
                    a = $urandom_range(0, P - 1);
                    b = (a + $urandom_range(1, P - 1)) % P;
                    set_digit(d, (P'(1) << a) | (P'(1) << b));
                end else begin
                    set_digit(d, P'($urandom));
                end
            end
            if ($urandom_range(0, 499) == 0) async_reset();
            else tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
